// File: rtl/seg_pkg.sv
// Code points and active-low a..g patterns shared by the seven-segment scan driver.
// Pattern bit 6 is segment a, bit 0 is segment g.
package seg_pkg;

   localparam int SEG_W = 8;

   localparam logic [3:0] CODE_DASH  = 4'd10;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_decode.sv
// Combinational 4-bit digit code to active-low a..g pattern.
// Codes 0..9 are numerals, CODE_DASH is a dash, everything else is blank.
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] i_code,
   output logic [6:0] o_seg
);

   always_comb begin
      // NOTE: default assigned first so no path through the case leaves o_seg unassigned (no latch).
      o_seg = SEG_BLANK;
      case (i_code)
         4'd0:      o_seg = SEG_0;
         4'd1:      o_seg = SEG_1;
         4'd2:      o_seg = SEG_2;
         4'd3:      o_seg = SEG_3;
         4'd4:      o_seg = SEG_4;
         4'd5:      o_seg = SEG_5;
         4'd6:      o_seg = SEG_6;
         4'd7:      o_seg = SEG_7;
         4'd8:      o_seg = SEG_8;
         4'd9:      o_seg = SEG_9;
         CODE_DASH: o_seg = SEG_DASH;
         default:   o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with a latched frame and active-low pins.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never blanked).
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [SEG_W-1:0]        seg
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]           r_cnt;
   logic [CNT_W-1:0]           w_cnt_next;
   logic [IDX_W-1:0]           r_idx;
   logic [IDX_W-1:0]           w_idx_next;
   logic [NUM_DIGITS-1:0][3:0] r_frame;
   logic [NUM_DIGITS-1:0]      r_dp;
   logic [NUM_DIGITS-1:0]      w_an_next;
   logic [3:0]                 w_code;
   logic [6:0]                 w_pattern;

   always_comb begin
      w_cnt_next = r_cnt + 1'b1;
      w_idx_next = r_idx;
      if (r_cnt == CNT_LAST) begin
         w_cnt_next = '0;
         w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
   end

   assign w_an_next = ~(NUM_DIGITS'(1) << w_idx_next);

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] w_lz_blank;

   // A digit is blanked when it and every digit above it hold code 0.
   always_comb begin
      logic w_run;
      w_run      = 1'b1;
      w_lz_blank = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         w_run         = w_run && (r_frame[k] == 4'd0);
         w_lz_blank[k] = w_run;
      end
   end

   assign w_code = w_lz_blank[w_idx_next] ? CODE_BLANK : r_frame[w_idx_next];
`else
   assign w_code = r_frame[w_idx_next];
`endif

   seg_decode u_decode (
      .i_code (w_code),
      .o_seg  (w_pattern)
   );

   // Outputs are decoded from the pre-edge frame, so a load shows one edge later.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      if (rst) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         // NOTE: the frame is a few flops, not a RAM, so it is cleared with the rest of the state.
         r_frame <= '0;
         r_dp    <= '0;
         an      <= '1;
         seg     <= '1;
      end else begin
         r_cnt <= w_cnt_next;
         r_idx <= w_idx_next;
         an    <= w_an_next;
         seg   <= {w_pattern, ~r_dp[w_idx_next]};
         if (load) begin
            r_frame <= digits_in;
            r_dp    <= dp_in;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// Expected pin values are pushed as each cycle is driven and popped after the edge.
`timescale 1ns/1ps
module tb_seg_scan_driver;

   localparam int ND = 4;
   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [3:0]  an;
   logic [7:0]  seg;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .load      (load),
      .an        (an),
      .seg       (seg)
   );

   int          total = 0;
   int          bad   = 0;
   logic [11:0] sb[$];
   int          n = 0;           // posedges since reset release
   logic [15:0] m_frame = '0;
   logic [3:0]  m_dp    = '0;

   function automatic logic [7:0] exp_seg(input logic [15:0] fr, input logic [3:0] dp, input int idx);
      logic [3:0]  code;
      logic [6:0]  p;
      logic [15:0] upper;
      code = fr[4*idx +: 4];
      case (code)
         4'd0:    p = 7'b0000001;
         4'd1:    p = 7'b1001111;
         4'd2:    p = 7'b0010010;
         4'd3:    p = 7'b0000110;
         4'd4:    p = 7'b1001100;
         4'd5:    p = 7'b0100100;
         4'd6:    p = 7'b0100000;
         4'd7:    p = 7'b0001111;
         4'd8:    p = 7'b0000000;
         4'd9:    p = 7'b0000100;
         4'd10:   p = 7'b1111110;
         default: p = 7'b1111111;
      endcase
      upper = fr >> (4 * idx);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (idx >= 1 && upper == 16'd0) p = 7'b1111111;
`endif
      if (upper == 16'hFFFF) p = p;  // keeps upper read in the default build
      return {p, ~dp[idx]};
   endfunction

   // Drive one cycle, push the pin values expected after the edge, wait to the sampling point.
   task automatic drive(input logic r, input logic ld, input logic [15:0] d, input logic [3:0] dp);
      logic [11:0] e;
      logic [3:0]  a;
      int          idx;
      rst       = r;
      load      = ld;
      digits_in = d;
      dp_in     = dp;
      if (r) begin
         e       = {4'hF, 8'hFF};
         n       = 0;
         m_frame = '0;
         m_dp    = '0;
      end else begin
         n   = n + 1;
         idx = (n / RD) % ND;
         a   = 4'b0001 << idx;
         e   = {~a, exp_seg(m_frame, m_dp, idx)};
         if (ld) begin
            m_frame = d;
            m_dp    = dp;
         end
      end
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_check(input string name, input int cycles);
      logic [11:0] e;
      for (int i = 0; i < cycles; i++) begin
         drive(1'b0, 1'b0, 16'h0, 4'h0);
         e = sb.pop_front();
         total++;
         if ({an, seg} !== e) begin
            bad++;
            $display("FAIL %s cycle %0d: an=%b seg=%b expected an=%b seg=%b", name, i, an, seg, e[11:8], e[7:0]);
         end
      end
   endtask

   task automatic test_reset();
      logic [11:0] e;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 16'h0, 4'h0);
         e = sb.pop_front();
         total++;
         if ({an, seg} !== e) begin
            bad++;
            $display("FAIL reset_hold %0d: an=%b seg=%b expected an=%b seg=%b", i, an, seg, e[11:8], e[7:0]);
         end
      end
      drive(1'b0, 1'b0, 16'h0, 4'h0);
      e = sb.pop_front();
      total++;
      if ({an, seg} !== e || an !== 4'b1110 || seg !== 8'b00000011) begin
         bad++;
         $display("FAIL first_edge: an=%b seg=%b expected an=1110 seg=00000011", an, seg);
      end
   endtask

   task automatic test_load(input string name, input logic [15:0] d, input logic [3:0] dp);
      logic [11:0] e;
      drive(1'b0, 1'b1, d, dp);
      e = sb.pop_front();
      total++;
      if ({an, seg} !== e) begin
         bad++;
         $display("FAIL %s load_edge: an=%b seg=%b expected an=%b seg=%b", name, an, seg, e[11:8], e[7:0]);
      end
      idle_check(name, 20);
   endtask

   task automatic test_load_during_reset();
      logic [11:0] e;
      drive(1'b1, 1'b1, 16'hFFFF, 4'hF);
      e = sb.pop_front();
      total++;
      if ({an, seg} !== e) begin
         bad++;
         $display("FAIL load_in_reset: an=%b seg=%b expected an=%b seg=%b", an, seg, e[11:8], e[7:0]);
      end
      idle_check("frame_after_load_in_reset", 17);
   endtask

   task automatic test_load_at_wrap();
      logic [11:0] e;
      int          guard = 0;
      while ((n + 1) % (ND * RD) != 0 && guard < 40) begin
         idle_check("align_wrap", 1);
         guard++;
      end
      total++;
      if ((n + 1) % (ND * RD) != 0) begin
         bad++;
         $display("FAIL align_wrap: index wrap not reached within %0d cycles", guard);
      end
      drive(1'b0, 1'b1, 16'h9876, 4'b0001);
      e = sb.pop_front();
      total++;
      if ({an, seg} !== e) begin
         bad++;
         $display("FAIL load_at_wrap: an=%b seg=%b expected an=%b seg=%b", an, seg, e[11:8], e[7:0]);
      end
      idle_check("after_wrap_load", 8);
   endtask

   task automatic test_reset_mid_scan();
      logic [11:0] e;
      int          guard = 0;
      while (n % (ND * RD) != 9 && guard < 40) begin
         idle_check("align_mid_slot", 1);
         guard++;
      end
      drive(1'b1, 1'b0, 16'h0, 4'h0);
      e = sb.pop_front();
      total++;
      if ({an, seg} !== e || an !== 4'b1111 || seg !== 8'hFF) begin
         bad++;
         $display("FAIL reset_mid_scan: an=%b seg=%b expected an=1111 seg=11111111", an, seg);
      end
      drive(1'b0, 1'b0, 16'h0, 4'h0);
      e = sb.pop_front();
      total++;
      if ({an, seg} !== e || an !== 4'b1110 || seg !== 8'b00000011) begin
         bad++;
         $display("FAIL restart_after_reset: an=%b seg=%b expected an=1110 seg=00000011", an, seg);
      end
      idle_check("restart_scan", 6);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         test_load("random", 16'($urandom), 4'($urandom_range(0, 15)));
      end
   endtask

   initial begin
      rst       = 1'b1;
      load      = 1'b0;
      digits_in = '0;
      dp_in     = '0;
      test_reset();
      test_load("load_1234", 16'h1234, 4'b0100);
      test_load("load_fa0f", 16'hFA0F, 4'b0000);
      test_load("load_0050", 16'h0050, 4'b0000);
      test_load_during_reset();
      test_load_at_wrap();
      test_reset_mid_scan();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed N-digit seven-segment display driver; the generalised successor to the single-digit BCD-to-segment decoder.
- Holds a latched frame of 4-bit digit codes plus decimal points. Scans digits at a programmable refresh rate and drives active-low anode and cathode lines directly to the board pins from the top module.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..16).
- REFRESH_DIV, 100000, clock cycles each digit is lit (1 ms at 100 MHz); minimum 2.
- CNT_W, $clog2(REFRESH_DIV), refresh counter width (derived, localparam).
- IDX_W, max(1,$clog2(NUM_DIGITS)), digit index width (derived, localparam).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- digits_in, in, 4*NUM_DIGITS, digit codes; digit k = digits_in[4k+3:4k]; digit 0 is rightmost.
- dp_in, in, NUM_DIGITS, decimal point request per digit (1 = lit).
- load, in, 1, single-cycle strobe that captures digits_in/dp_in into the frame latch.
- an, out, NUM_DIGITS, anode enables, active-low, one-cold.
- seg, out, 8, cathodes, active-low; seg[7:1] = a..g, seg[0] = dp.

Behaviour:
- Reset (rst=1 at posedge):
  - refresh counter = 0, digit index = 0, frame latch digits = 0, dp latch = 0.
  - an = all ones (all digits off), seg = 8'hFF (blank).
- Frame latch:
  - When load=1 at posedge, digits_in and dp_in are captured. The new values are visible on seg from the next posedge onward.
  - load is ignored while rst=1.
  - The latch holds its contents indefinitely when load=0.
- Refresh counter: increments every cycle. At REFRESH_DIV-1 it wraps to 0 and the digit index advances.
- Digit index wraps from NUM_DIGITS-1 to 0. With NUM_DIGITS=1 the index stays 0 and an is constantly 0 after reset.
- Outputs are registered:
  - At each posedge (not in reset), an = ~(1 << idx_next) and seg = decode(frame[idx_next]), dp from dp latch.
  - idx_next is the index value after this edge's update.
  - Consequence: the first posedge after reset release gives an = ~1 with digit 0 decoded.
  - Each digit stays lit for exactly REFRESH_DIV cycles, except digit 0 after reset, which is lit for REFRESH_DIV-1.
- Decode (active-low a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - 10 = dash 1111110.
  - 11..15 = blank 1111111.
- dp: seg[0] = ~dp_latch[idx]. A blanked digit still shows its dp if requested.
- Simultaneous load and index advance: the captured value applies on the following edge; there is no tear within a single digit slot.
- Reset mid-scan: the block returns to the reset state in one cycle and the frame is cleared.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: digit k (k ≥ 1) shows blank segments (a..g = 1111111) when its code is 0 and every digit above it is also 0. Digit 0 is never blanked.
  - The zero-run mask is computed combinationally from the frame latch.
  - dp still follows dp_latch.
- Undefined: zeros always display as "0".

Decomposition:
- Package seg_pkg holds:
  - SEG_W=8.
  - Code constants CODE_DASH=4'd10 and CODE_BLANK=4'd15.
  - 7-bit pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
- Sub-module seg_decode: combinational 4-bit code to 7-bit a..g pattern using the package constants. One instance, on the muxed digit.
- Counter, index, frame latch and output registers stay in seg_scan_driver.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
- Reset hold 3 cycles, then release -> during reset an=4'b1111 and seg=8'hFF. First edge after release gives an=4'b1110 and seg=8'b00000011.
- Load digits_in=16'h1234, dp_in=4'b0100 -> over 16 cycles an cycles 1110→1101→1011→0111, 4 cycles each:
  - digit 0: seg=10011001 ("4").
  - digit 1: seg=00001101 ("3").
  - digit 2: seg=00100100 ("2", dp lit).
  - digit 3: seg=10011111 ("1").
- Load digits_in=16'hFA0F, dp_in=0 -> digit0 blank 11111111, digit1 "0" 00000011, digit2 dash 11111101, digit3 blank 11111111.
- Load digits_in=16'h0050 with SEG_LEADING_ZERO_BLANK_EN defined -> digit3 and digit2 give 11111111, digit1 "5" 01001001, digit0 "0" 00000011. Without the macro, digit3 and digit2 give 00000011.
- Assert load and rst in the same cycle -> frame stays 0 and outputs are the reset values. A load pulse in the cycle the index wraps takes effect one edge later without glitching an.
- Assert rst mid-slot on digit 2 -> next edge an=1111, seg=FF. After release, the scan restarts at digit 0 showing "0".
